tl_intersection_model: RTL

TL_INTERSECTION_MODEL -- requirements
Module: tl_intersection_model

---
 rtl/tl_model_pkg.sv | 36 +++
 rtl/tl_lane_queue.sv | 42 ++++
 rtl/tl_intersection_model.sv | 83 ++++++++
 3 files changed

// File: rtl/tl_model_pkg.sv
// Shared constants for the intersection queue model: light encoding (common
// with the traffic-light controller), approach FSM states and queue sizing.
package tl_model_pkg;

    // Light encoding driven by the traffic-light controller.
    localparam logic [1:0] LIGHT_GREEN  = 2'b00;
    localparam logic [1:0] LIGHT_YELLOW = 2'b01;
    localparam logic [1:0] LIGHT_RED    = 2'b10;
    localparam logic [1:0] LIGHT_LEFT   = 2'b11;

    // Per-approach FSM states.
    localparam logic [2:0] ST_STOP    = 3'd0;
    localparam logic [2:0] ST_START_S = 3'd1;
    localparam logic [2:0] ST_FLOW_S  = 3'd2;
    localparam logic [2:0] ST_START_L = 3'd3;
    localparam logic [2:0] ST_FLOW_L  = 3'd4;

    // Lane queue counter width and saturation value.
    localparam int             Q_W   = 3;
    localparam logic [Q_W-1:0] Q_MAX = 3'd7;

    // Next approach state from the current state and the light seen this cycle.
    // A movement needs one START cycle before it flows; any yellow/red stops it.
    function automatic logic [2:0] next_approach_state(input logic [2:0] state,
                                                       input logic [1:0] light);
        logic [2:0] nxt;
        nxt = ST_STOP;
        case (light)
            LIGHT_GREEN: nxt = (state == ST_START_S || state == ST_FLOW_S) ? ST_FLOW_S : ST_START_S;
            LIGHT_LEFT:  nxt = (state == ST_START_L || state == ST_FLOW_L) ? ST_FLOW_L : ST_START_L;
            default:     nxt = ST_STOP;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/tl_lane_queue.sv
// One lane's saturating car counter (0..Q_MAX) with occupancy sensor and a
// sticky overflow flag for arrivals dropped while full.
module tl_lane_queue
    import tl_model_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    input  logic           inc,
    input  logic           dec,
    output logic [Q_W-1:0] count,
    output logic           sensor,
    output logic           ovf
);

    logic [Q_W-1:0] r_count;
    logic           r_ovf;
    logic           w_dec_ok;

    // A departure only happens when there is a car to leave.
    assign w_dec_ok = dec && (r_count != '0);

    // Count update: arrival+departure cancel, full arrivals are dropped and flagged.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else if (inc && !w_dec_ok) begin
            if (r_count == Q_MAX) begin
                r_ovf <= 1'b1;
            end else begin
                r_count <= r_count + 3'd1;
            end
        end else if (w_dec_ok && !inc) begin
            r_count <= r_count - 3'd1;
        end
    end

    assign count  = r_count;
    assign sensor = (r_count != '0);
    assign ovf    = r_ovf;

endmodule

// File: rtl/tl_intersection_model.sv
// Intersection plant model: four lane queues drained by two approach FSMs
// that follow the lights, plus a sticky flag for unsafe light combinations.
module tl_intersection_model
    import tl_model_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    input  logic [1:0]     La,
    input  logic [1:0]     Lb,
    input  logic           arr_a,
    input  logic           arr_b,
    input  logic           arr_al,
    input  logic           arr_bl,
    output logic           Ta,
    output logic           Tb,
    output logic           Tal,
    output logic           Tbl,
    output logic [Q_W-1:0] q_a,
    output logic [Q_W-1:0] q_b,
    output logic [Q_W-1:0] q_al,
    output logic [Q_W-1:0] q_bl,
    output logic [3:0]     ovf,
    output logic           conflict,
    output logic [2:0]     o_dbg_state_a,
    output logic [2:0]     o_dbg_state_b
);

    logic [2:0] r_state_a;
    logic [2:0] r_state_b;
    logic       r_conflict;
    logic [2:0] w_next_a;
    logic [2:0] w_next_b;
    logic       w_ovf_a;
    logic       w_ovf_b;
    logic       w_ovf_al;
    logic       w_ovf_bl;

    assign w_next_a = next_approach_state(r_state_a, La);
    assign w_next_b = next_approach_state(r_state_b, Lb);

    // Approach FSMs and the sticky conflict flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_a  <= ST_STOP;
            r_state_b  <= ST_STOP;
            r_conflict <= 1'b0;
        end else begin
            r_state_a <= w_next_a;
            r_state_b <= w_next_b;
            if (La != LIGHT_RED && Lb != LIGHT_RED) begin
                r_conflict <= 1'b1;
            end
        end
    end

    // Departures are keyed on the state being entered, so the START cycle
    // that follows a light change is the one lost to start-up.
    tl_lane_queue u_q_a (
        .clk(clk), .reset(reset), .inc(arr_a), .dec(w_next_a == ST_FLOW_S),
        .count(q_a), .sensor(Ta), .ovf(w_ovf_a)
    );

    tl_lane_queue u_q_b (
        .clk(clk), .reset(reset), .inc(arr_b), .dec(w_next_b == ST_FLOW_S),
        .count(q_b), .sensor(Tb), .ovf(w_ovf_b)
    );

    tl_lane_queue u_q_al (
        .clk(clk), .reset(reset), .inc(arr_al), .dec(w_next_a == ST_FLOW_L),
        .count(q_al), .sensor(Tal), .ovf(w_ovf_al)
    );

    tl_lane_queue u_q_bl (
        .clk(clk), .reset(reset), .inc(arr_bl), .dec(w_next_b == ST_FLOW_L),
        .count(q_bl), .sensor(Tbl), .ovf(w_ovf_bl)
    );

    assign ovf           = {w_ovf_bl, w_ovf_al, w_ovf_b, w_ovf_a};
    assign conflict      = r_conflict;
    assign o_dbg_state_a = r_state_a;
    assign o_dbg_state_b = r_state_b;

endmodule
